// File: rtl/clk_wiz_pkg.sv
`timescale 1ns / 1ps
// clk_wiz_pkg: shared limits, defaults and sizing helper for the clock wizard.
package clk_wiz_pkg;

  localparam int DIVIDE_MAX          = 256;
  localparam int LOCK_CYCLES_MAX     = 1 << 20;
  localparam int LOCK_CYCLES_DEFAULT = 1024;

  // Ceiling log2 with a floor of one bit, used to size the divider and lock counters.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rst_sync_n.sv
`timescale 1ns / 1ps
// rst_sync_n: asynchronous-assert, synchronous-deassert two-flop reset synchronizer.
module rst_sync_n (
  input  logic clk,
  input  logic arst_n,
  output logic srst_n
);

  logic meta_q;
  logic sync_q;

  // Reset drops both flops at once; release ripples through on two rising edges.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= 1'b1;
      sync_q <= meta_q;
    end
  end

  assign srst_n = sync_q;

endmodule

// File: rtl/clk_div_wizard.sv
`timescale 1ns / 1ps
// clk_div_wizard: integer clock divider with a lock indication.
// Optional macro CLK_WIZ_SAFE_STARTUP_EN: keep the divider idle and clk_out1 low
// until locked rises; without it the divider runs as soon as internal reset lifts.
module clk_div_wizard
  import clk_wiz_pkg::*;
#(
  parameter int DIVIDE           = 1,
  parameter int LOCK_CYCLES      = LOCK_CYCLES_DEFAULT,
  parameter int CLK_IN_PERIOD_PS = 10000
) (
  input  logic clk_in1,
  input  logic resetn,
  output logic clk_out1,
  output logic locked
);

  localparam int            LW          = clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_TARGET = LW'(LOCK_CYCLES);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CYCLES - 1);

  if (DIVIDE < 1 || DIVIDE > DIVIDE_MAX) begin : g_bad_divide
    $error("clk_div_wizard: DIVIDE must be within 1..%0d", DIVIDE_MAX);
  end
  if (LOCK_CYCLES < 1 || LOCK_CYCLES > LOCK_CYCLES_MAX) begin : g_bad_lock
    $error("clk_div_wizard: LOCK_CYCLES must be within 1..%0d", LOCK_CYCLES_MAX);
  end
  if (CLK_IN_PERIOD_PS <= 0) begin : g_bad_period
    $error("clk_div_wizard: CLK_IN_PERIOD_PS must be positive");
  end

  logic          rstn_sync;
  logic [LW-1:0] lock_cnt;
  logic          lock_hit;
  logic          div_en;

  rst_sync_n u_rst_sync (
    .clk    (clk_in1),
    .arst_n (resetn),
    .srst_n (rstn_sync)
  );

  // lock_hit is the value locked takes on this edge, so gating can open in step with it.
  assign lock_hit = locked | (lock_cnt == LOCK_LAST);

`ifdef CLK_WIZ_SAFE_STARTUP_EN
  assign div_en = lock_hit;
`else
  assign div_en = 1'b1;
`endif

  // Lock counter saturates at LOCK_CYCLES; locked then holds until reset.
  always_ff @(posedge clk_in1 or negedge rstn_sync) begin
    if (!rstn_sync) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (lock_cnt != LOCK_TARGET) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      locked <= lock_hit;
    end
  end

  if (DIVIDE == 1) begin : g_bypass
    logic gate_q;

    // Gate moves only while clk_in1 is low, so the output never starts or ends mid-pulse.
    always_ff @(negedge clk_in1 or negedge rstn_sync) begin
      if (!rstn_sync) begin
        gate_q <= 1'b0;
      end else begin
        gate_q <= div_en;
      end
    end

    assign clk_out1 = clk_in1 & gate_q;
  end else begin : g_divide
    localparam int            CW       = clog2(DIVIDE);
    localparam int            HIGH     = (DIVIDE + 1) / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDE - 1);
    localparam logic [CW-1:0] CNT_HIGH = CW'(HIGH);

    logic [CW-1:0] cnt;
    logic          out_q;

    // Phase counter wraps every DIVIDE edges; output is high for the first HIGH counts.
    always_ff @(posedge clk_in1 or negedge rstn_sync) begin
      if (!rstn_sync) begin
        cnt   <= '0;
        out_q <= 1'b0;
      end else if (!div_en) begin
        cnt   <= '0;
        out_q <= 1'b0;
      end else begin
        out_q <= (cnt < CNT_HIGH);
        cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end

    assign clk_out1 = out_q;
  end

endmodule

// File: tb/tb_clk_div_wizard.sv
`timescale 1ns / 1ps
// tb_clk_div_wizard: six divider instances sharing one clock and reset, checked
// against an edge-count model under random reset placement and run lengths.
module tb_clk_div_wizard;

`ifdef CLK_WIZ_SAFE_STARTUP_EN
  localparam bit SAFE = 1'b1;
`else
  localparam bit SAFE = 1'b0;
`endif

  localparam int NUM = 6;

  int divs[NUM] = '{1, 2, 3, 4, 7, 256};
  int lcs[NUM]  = '{16, 16, 1, 16, 5, 3};

  logic           clk;
  logic           resetn;
  logic [NUM-1:0] clkOut;
  logic [NUM-1:0] lockedOut;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  clk_div_wizard #(.DIVIDE(1),   .LOCK_CYCLES(16), .CLK_IN_PERIOD_PS(10000)) u0 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[0]), .locked(lockedOut[0]));
  clk_div_wizard #(.DIVIDE(2),   .LOCK_CYCLES(16), .CLK_IN_PERIOD_PS(10000)) u1 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[1]), .locked(lockedOut[1]));
  clk_div_wizard #(.DIVIDE(3),   .LOCK_CYCLES(1),  .CLK_IN_PERIOD_PS(10000)) u2 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[2]), .locked(lockedOut[2]));
  clk_div_wizard #(.DIVIDE(4),   .LOCK_CYCLES(16), .CLK_IN_PERIOD_PS(10000)) u3 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[3]), .locked(lockedOut[3]));
  clk_div_wizard #(.DIVIDE(7),   .LOCK_CYCLES(5),  .CLK_IN_PERIOD_PS(10000)) u4 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[4]), .locked(lockedOut[4]));
  clk_div_wizard #(.DIVIDE(256), .LOCK_CYCLES(3),  .CLK_IN_PERIOD_PS(10000)) u5 (
    .clk_in1(clk), .resetn(resetn), .clk_out1(clkOut[5]), .locked(lockedOut[5]));

  // 100 MHz reference clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Output level k rising edges after reset release, in the high or low half of that cycle.
  function automatic bit modelClk(input int div, input int lc, input int edgeNum, input bit highPhase);
    int start;
    start = SAFE ? lc + 2 : 3;
    if (edgeNum < start) return 1'b0;
    if (div == 1) return highPhase;
    return ((edgeNum - start) % div) < ((div + 1) / 2);
  endfunction

  function automatic bit modelLocked(input int lc, input int edgeNum);
    return edgeNum >= lc + 2;
  endfunction

  task automatic checkAllZero(input string tag);
    for (int i = 0; i < NUM; i++) begin
      checkOutput($sformatf("%s clk u%0d", tag, i), {31'd0, clkOut[i]}, 32'd0);
      checkOutput($sformatf("%s locked u%0d", tag, i), {31'd0, lockedOut[i]}, 32'd0);
    end
  endtask

  task automatic checkModel(input bit highPhase);
    for (int i = 0; i < NUM; i++) begin
      checkOutput($sformatf("clk u%0d k=%0d hi=%0d", i, k, highPhase), {31'd0, clkOut[i]},
                  {31'd0, modelClk(divs[i], lcs[i], k, highPhase)});
      checkOutput($sformatf("locked u%0d k=%0d", i, k), {31'd0, lockedOut[i]},
                  {31'd0, modelLocked(lcs[i], k)});
    end
  endtask

  // Run n clock cycles, sampling 1 ns after each rising and each falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      k = k + 1;
      #1;
      checkModel(1'b1);
      @(negedge clk);
      #1;
      checkModel(1'b0);
    end
  endtask

  // Assert reset away from any edge, confirm outputs clear at once, hold, then release mid-low-phase.
  task automatic applyReset(input bit randomPhase, input int holdEdges);
    if (randomPhase) begin
      if ($urandom_range(1) == 1) @(posedge clk);
      else @(negedge clk);
      #($urandom_range(1, 3));
    end else begin
      #1;
    end
    resetn = 1'b0;
    #1;
    checkAllZero("reset_immediate");
    repeat (holdEdges) begin
      @(posedge clk);
      #1;
      checkAllZero("reset_hold");
    end
    @(negedge clk);
    #2;
    resetn = 1'b1;
    k = 0;
  endtask

  // Pulse-width watchdogs: no high or low phase narrower than one clk_in1 phase,
  // except a high pulse cut short by reset.
  for (genvar g = 0; g < NUM; g++) begin : g_mon
    realtime riseT = 0.0;
    realtime fallT = 0.0;
    bit      riseSeen = 1'b0;
    bit      fallSeen = 1'b0;

    always @(posedge clkOut[g]) begin
      if (fallSeen) begin
        checkOutput($sformatf("low_width u%0d", g), {31'd0, ($realtime - fallT) >= 4.999}, 32'd1);
      end
      riseT    = $realtime;
      riseSeen = 1'b1;
    end

    always @(negedge clkOut[g]) begin
      if (riseSeen && resetn) begin
        checkOutput($sformatf("high_width u%0d", g), {31'd0, ($realtime - riseT) >= 4.999}, 32'd1);
      end
      fallT    = $realtime;
      fallSeen = 1'b1;
      riseSeen = 1'b0;
    end
  end

  initial begin
    int guard;
    $display("[TB] start, safe startup = %0d", SAFE);
    resetn = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    checkAllZero("power_on");
    repeat (3) begin
      @(posedge clk);
      #1;
      checkAllZero("power_on_hold");
    end
    @(negedge clk);
    #2;
    resetn = 1'b1;
    k = 0;

    applyStimulus(40);
    guard = 0;
    while (!modelClk(4, 16, k, 1'b1) && guard < 8) begin
      applyStimulus(1);
      guard = guard + 1;
    end
    checkOutput("u3 high before reset", {31'd0, clkOut[3]}, 32'd1);
    applyReset(1'b0, 2);

    repeat (10) begin
      applyStimulus($urandom_range(10, 600));
      applyReset(1'b1, $urandom_range(1, 4));
    end
    applyStimulus(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
